// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for the ID stage: stalls RAW consumers of in-flight writers,
// keeps the longest pending write on WAW, and can squash the previous cycle's issue. Optional HAZARD_PERF_EN adds a stall counter.
module hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_rs1_en,
    input  logic                id_rs2_en,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_rd_en,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]         perf_stall_cnt
`endif
);

    localparam logic [REG_W:0] NREG = (REG_W+1)'(NUM_REGS);

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] x);
        return (x != '0) ? x - CNT_W'(1) : '0;
    endfunction

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic             last_vld;
    logic [REG_W-1:0] last_rd;
    logic [CNT_W-1:0] last_prev;

    logic             rs1_ok, rs2_ok, rd_ok;
    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, rd_dec, rd_new;
    logic             hazard, wr_en;

    // Selects beyond NUM_REGS read as idle and never create an entry.
    always_comb begin
        rs1_ok  = {1'b0, id_rs1} < NREG;
        rs2_ok  = {1'b0, id_rs2} < NREG;
        rd_ok   = {1'b0, id_rd} < NREG;
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        if (rs1_ok) rs1_cnt = cnt[id_rs1];
        if (rs2_ok) rs2_cnt = cnt[id_rs2];
        if (rd_ok)  rd_cnt  = cnt[id_rd];
        hazard  = (id_rs1_en && (rs1_cnt != '0)) || (id_rs2_en && (rs2_cnt != '0));
        rd_dec  = dec(rd_cnt);
        rd_new  = (id_lat > rd_dec) ? id_lat : rd_dec;
    end

    // id_valid is the request, issue the acceptance and stall the back-pressure:
    // a stalled instruction stays in ID unchanged; flush kills it without either.
    assign stall = id_valid && hazard && !flush;
    assign issue = id_valid && !hazard && !flush;
    assign wr_en = issue && id_rd_en && (id_lat != '0) && rd_ok;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = dec(cnt[r]);
        end
        if (wr_en) begin
            cnt_nxt[id_rd] = rd_new;
        end
        // Undo the squashed issue: the value it would have decayed to without that write.
        if (flush && last_vld) begin
            cnt_nxt[last_rd] = dec(last_prev);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            last_vld  <= 1'b0;
            last_rd   <= '0;
            last_prev <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            last_vld <= wr_en;
            if (wr_en) begin
                last_rd   <= id_rd;
                last_prev <= rd_dec;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (stall && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a ready-time model (absolute cycle at which each register frees)
// is compared every cycle, with directed literal checks and randomized traffic.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_rs1_en, id_rs2_en, id_rd_en, flush;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_lat;
    logic       stall, issue;
    logic [7:0] busy;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    hazard_scoreboard #(.NUM_REGS(8), .REG_W(3), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd_en(id_rd_en), .id_rd(id_rd), .id_lat(id_lat),
        .flush(flush), .stall(stall), .issue(issue), .busy(busy)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: ready[r] = first cycle at which register r no longer blocks
    int ready [8];
    int now;
    bit pend_vld;
    int pend_rd;
    int pend_old;
    int exp_perf;

    function automatic bit reg_busy(input int r);
        return (r < 8) && (ready[r] > now);
    endfunction

    function automatic bit exp_hazard();
        return (id_rs1_en && reg_busy(int'(id_rs1))) || (id_rs2_en && reg_busy(int'(id_rs2)));
    endfunction

    function automatic int exp_busy();
        int v = 0;
        for (int r = 0; r < 8; r++) if (reg_busy(r)) v |= (1 << r);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) ready[r] = 0;
            now = 0; pend_vld = 0; pend_rd = 0; pend_old = 0; exp_perf = 0;
        end else begin
            bit eh, ei, es;
            eh = exp_hazard();
            es = id_valid && eh && !flush;
            ei = id_valid && !eh && !flush;
            if (es && exp_perf < 65535) exp_perf++;
            if (flush && pend_vld) ready[pend_rd] = pend_old;
            pend_vld = 0;
            if (ei && id_rd_en && id_lat != 0) begin
                pend_vld = 1;
                pend_rd  = int'(id_rd);
                pend_old = ready[pend_rd];
                if (now + 1 + int'(id_lat) > ready[pend_rd]) ready[pend_rd] = now + 1 + int'(id_lat);
            end
            now++;
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        bit eh;
        eh = exp_hazard();
        chk("stall", int'(stall), int'(id_valid && eh && !flush));
        chk("issue", int'(issue), int'(id_valid && !eh && !flush));
        chk("busy",  int'(busy),  exp_busy());
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", int'(perf_stall_cnt), exp_perf);
`endif
    end

    // driver tasks
    task automatic set_in(input logic v, input logic r1e, input logic [2:0] r1,
                          input logic r2e, input logic [2:0] r2, input logic rde,
                          input logic [2:0] rd, input logic [1:0] lat, input logic fl);
        id_valid = v; id_rs1_en = r1e; id_rs1 = r1; id_rs2_en = r2e; id_rs2 = r2;
        id_rd_en = rde; id_rd = rd; id_lat = lat; flush = fl;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) nxt();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_stall", int'(stall), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // back-to-back RAW, latency 2
        set_in(1, 0, 0, 0, 0, 1, 3, 2, 0);
        @(negedge clk); chk("raw_producer_issue", int'(issue), 1); nxt();
        set_in(1, 1, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("raw_stall_t1", int'(stall), 1); nxt();
        @(negedge clk); chk("raw_stall_t2", int'(stall), 1); nxt();
        @(negedge clk); chk("raw_issue_t3", int'(issue), 1); chk("raw_nostall_t3", int'(stall), 0); nxt();
        idle(3);

        // forwarded producer
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 0); nxt();
        set_in(1, 0, 0, 1, 5, 0, 0, 0, 0);
        @(negedge clk); chk("fwd_stall", int'(stall), 0); chk("fwd_busy5", int'(busy[5]), 0); nxt();
        idle(1);

        // WAW: longer pending write wins
        set_in(1, 0, 0, 0, 0, 1, 1, 3, 0); nxt();
        set_in(1, 0, 0, 0, 0, 1, 1, 1, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("waw_busy1_t2", int'(busy[1]), 1); nxt();
        @(negedge clk); chk("waw_busy1_t3", int'(busy[1]), 1); nxt();
        @(negedge clk); chk("waw_busy1_t4", int'(busy[1]), 0); nxt();

        // flush cancels previous issue; flush beats hazard
        set_in(1, 0, 0, 0, 0, 1, 4, 2, 0); nxt();
        set_in(1, 1, 4, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk("flush_stall", int'(stall), 0); chk("flush_issue", int'(issue), 0); nxt();
        set_in(1, 1, 4, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("flush_cons_issue", int'(issue), 1); chk("flush_busy4", int'(busy[4]), 0); nxt();
        idle(1);

        // unused source and self-dependency
        set_in(1, 0, 0, 0, 0, 1, 6, 3, 0); nxt();
        set_in(1, 0, 6, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("unused_src_issue", int'(issue), 1); nxt();
        set_in(1, 1, 2, 0, 0, 1, 2, 2, 0);
        @(negedge clk); chk("self_dep_issue", int'(issue), 1); nxt();
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("self_dep_next_stall", int'(stall), 1); nxt();
        idle(4);

        // async reset during a stall
        set_in(1, 0, 0, 0, 0, 1, 7, 2, 0); nxt();
        set_in(1, 1, 7, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("pre_reset_stall", int'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_stall", int'(stall), 0);
`ifdef HAZARD_PERF_EN
        chk("async_reset_perf", int'(perf_stall_cnt), 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("post_reset_issue", int'(issue), 1); nxt();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 4) != 0, 1'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0);
            if (i == 1500) begin
                #($urandom_range(1, 7));
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end else begin
                nxt();
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard hazard unit for the in-order WISC pipeline, in the decode (ID) stage. It replaces fixed two-stage write-select compares with per-register countdown counters, so any number of in-flight writers with per-instruction result latency is tracked. It supports wrong-path squash of the most recent issue and optional stall-cycle accounting. Its outputs drive the PC/IF-ID hold and the ID/EX bubble insert.

## Interface
Parameters:
- NUM_REGS, 8, architectural registers tracked; register 0 is an ordinary register.
- REG_W, 3, register-select width; must satisfy 2^REG_W >= NUM_REGS.
- CNT_W, 2, counter width; maximum latency class is 2^CNT_W-1.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_en, id_rs2_en  in  1 each  source operand actually read.
- id_rs1, id_rs2  in  REG_W each  source register selects.
- id_rd_en  in  1  instruction writes a register.
- id_rd  in  REG_W  destination select.
- id_lat  in  CNT_W  stall cycles owed to an immediately following consumer of id_rd (0 = fully forwarded, no entry).
- flush  in  1  squash the ID instruction and cancel the entry from the previous cycle's issue.
- stall  out  1  hold PC and IF/ID and insert a bubble into ID/EX.
- issue  out  1  ID instruction advances this cycle.
- busy  out  NUM_REGS  bit r set when cnt[r] != 0.
- perf_stall_cnt  out  16  present only with HAZARD_PERF_EN.

## Operation
- State: cnt[0..NUM_REGS-1] (CNT_W each), last_vld, last_rd, last_prev (CNT_W).
- dec(x) = x-1 if x != 0, else 0 (saturating decrement).
- hazard = (id_rs1_en & cnt[id_rs1] != 0) | (id_rs2_en & cnt[id_rs2] != 0). The check uses current-cycle counter values.
- stall = id_valid & hazard & ~flush.
- issue = id_valid & ~hazard & ~flush.
- Every cycle, each counter updates to dec(cnt[r]) unless it is overridden by one of the two rules below.
- Issue with id_rd_en and id_lat != 0: cnt[id_rd] <= max(dec(cnt[id_rd]), id_lat). This is the WAW rule; the longer pending write wins.
  - Also on such an issue: last_vld <= 1, last_rd <= id_rd, last_prev <= dec(cnt[id_rd]).
- Any other cycle: last_vld <= 0.
- flush with last_vld = 1: cnt[last_rd] <= dec(last_prev). This restores the counter as if the squashed issue never occurred. It takes priority over the decrement rule.
- An instruction whose source equals its own destination checks the pre-issue counter value, so it never self-stalls.
- Register selects >= NUM_REGS are treated as not busy and are never recorded.

## Timing
- Reset (async assert): all cnt = 0, last_vld = 0, last_rd = 0, last_prev = 0, busy = 0, perf_stall_cnt = 0. stall and issue follow the combinational equations (stall = 0 while counters are 0).
- stall, issue and busy are combinational from the inputs and current state, with zero latency.
- A producer issuing at cycle t with latency L forces a dependent ID instruction to stall in cycles t+1..t+L; that instruction issues at t+L+1.
- L = 2 reproduces the classic no-forwarding 5-stage behaviour (EX and MEM writers).
- flush and hazard in the same cycle: stall = 0, issue = 0. Flush wins.
- Reset asserted mid-operation discards all pending entries immediately. The first post-reset instruction never stalls.

## Configuration
- HAZARD_PERF_EN defined: the perf_stall_cnt port exists. It increments on each cycle with stall = 1 and saturates at 16'hFFFF.
- HAZARD_PERF_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Back-to-back RAW: producer rd=3, lat=2 issues at t; consumer rs1=3 in ID at t+1 -> stall=1 at t+1 and t+2, issue=1 at t+3.
- Forwarded producer: lat=0 on rd=5, consumer rs2=5 next cycle -> stall never asserts, busy stays 0.
- WAW: rd=1 lat=3 at t, rd=1 lat=1 at t+1 -> cnt[1]=2 at t+2 (max rule), busy[1] clears at t+4.
- Flush: rd=4 lat=2 issues at t, flush=1 at t+1 -> cnt[4]=0 at t+2; a consumer of r4 at t+2 issues with no stall; issue=0 at t+1.
- Unused source: rs1=6 with id_rs1_en=0 while r6 is busy -> no stall. Self-dependency rs1=rd=2 with r2 idle -> issue=1.
- Async reset during a stall (cnt[7]=2) -> busy=0 and stall=0 immediately. With HAZARD_PERF_EN: perf_stall_cnt=0 after reset and equals the stall-cycle count over a 10-cycle run.
